pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB from three sources:
  - load-use detection;
  - taken branches resolved in EX;
  - a data-memory req/ack handshake with timeout.
- Holds a memory-wait FSM, a timeout counter and a saturating stall-cycle counter.
- Sits beside the pipeline registers and updates on the same clock edge they use.

---
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. It combines load-use detection,
// taken-branch flushes and a data-memory req/ack handshake with a timeout into the
// enable/flush controls of the pipeline registers. State updates on negedge clk,
// the same edge the pipeline registers use.
module pipe_hazard_ctrl #(
    parameter int unsigned WAIT_MAX = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_MemtoReg,
    input  logic [4:0]       ex_rw,
    input  logic             ex_branch_taken,
    input  logic             mem_MemWr,
    input  logic             mem_MemtoReg,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_bubble,
    output logic             mem_req,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned TW = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {StRun, StWait, StErr} state_t;

    state_t           state_q;
    logic [TW-1:0]    tcnt_q;
    logic             bus_err_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic memop;
    logic freeze;
    logic lduse;
    logic lduse_stall;

    // Hazard qualifiers derived from the current state and pipeline contents.
    always_comb begin
        memop  = mem_MemWr | mem_MemtoReg;
        freeze = ((state_q == StRun) & memop & ~mem_ack) |
                 ((state_q == StWait) & ~mem_ack) |
                 (state_q == StErr);
        lduse  = ex_MemtoReg & (ex_rw != 5'd0) &
                 ((ex_rw == id_rs) | (id_uses_rt & (ex_rw == id_rt)));
        // A load-use stall only happens when neither a freeze nor a branch outranks it.
        lduse_stall = ~freeze & ~ex_branch_taken & lduse;
    end

    // Prioritised pipeline controls; everything is held inactive while in reset.
    always_comb begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b0;
        mem_req       = 1'b0;
        if (rst) begin
            mem_req = memop & (state_q != StErr);
            if (freeze) begin
                mem_wb_bubble = 1'b1;
            end else if (ex_branch_taken) begin
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_en    = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_en   = 1'b1;
            end else if (lduse) begin
                id_ex_en    = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_en   = 1'b1;
            end else begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
            end
        end
    end

    // Memory-wait FSM with timeout counter and sticky bus error.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StRun;
            tcnt_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    // An ack with no memop pending is ignored here.
                    if (memop && !mem_ack) begin
                        state_q <= StWait;
                        tcnt_q  <= TW'(1);
                    end
                end
                StWait: begin
                    if (mem_ack) begin
                        state_q <= StRun;
                        tcnt_q  <= '0;
                    end else if (tcnt_q == TW'(WAIT_MAX)) begin
                        state_q   <= StErr;
                        bus_err_q <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                StErr: begin
                    state_q <= StErr;
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the front of the pipeline did not advance.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if ((freeze || lduse_stall) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus_err   = bus_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (WAIT_MAX=4, CNT_W=4). Inputs change on
// posedge, combinational controls are sampled just after, registered state just after
// the active negedge. Expected values are queued at drive time and popped at sampling.
module tb_pipe_hazard_ctrl;

    localparam int unsigned WAIT_MAX = 4;
    localparam int unsigned CNT_W    = 4;

    // Control vector: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    //                  ex_mem_en, mem_wb_bubble, mem_req}
    localparam logic [7:0] C_OFF  = 8'b0000_0000;
    localparam logic [7:0] C_RUN  = 8'b1101_0100;
    localparam logic [7:0] C_RUNR = 8'b1101_0101;
    localparam logic [7:0] C_FRZ  = 8'b0000_0011;
    localparam logic [7:0] C_ERR  = 8'b0000_0010;
    localparam logic [7:0] C_BR   = 8'b1111_1100;
    localparam logic [7:0] C_BRR  = 8'b1111_1101;
    localparam logic [7:0] C_LDU  = 8'b0001_1100;
    localparam logic [7:0] C_LDUR = 8'b0001_1101;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
        logic       ld;
        logic [4:0] rw;
        logic       br;
        logic       mwr;
        logic       mld;
        logic       ack;
    } in_t;

    typedef struct packed {
        logic [7:0]       ctl;
        logic [CNT_W-1:0] cnt;
        logic             berr;
    } exp_t;

    typedef struct packed {
        in_t  in;
        exp_t e;
    } step_t;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_MemtoReg;
    logic [4:0]       ex_rw;
    logic             ex_branch_taken;
    logic             mem_MemWr;
    logic             mem_MemtoReg;
    logic             mem_ack;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic             mem_wb_bubble;
    logic             mem_req;
    logic             bus_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [7:0]       ctl;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    pipe_hazard_ctrl #(
        .WAIT_MAX(WAIT_MAX),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .ex_MemtoReg    (ex_MemtoReg),
        .ex_rw          (ex_rw),
        .ex_branch_taken(ex_branch_taken),
        .mem_MemWr      (mem_MemWr),
        .mem_MemtoReg   (mem_MemtoReg),
        .mem_ack        (mem_ack),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .if_id_flush    (if_id_flush),
        .id_ex_en       (id_ex_en),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_en      (ex_mem_en),
        .mem_wb_bubble  (mem_wb_bubble),
        .mem_req        (mem_req),
        .bus_err        (bus_err),
        .stall_cnt      (stall_cnt)
    );

    assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                  ex_mem_en, mem_wb_bubble, mem_req};

    initial clk = 1'b1;
    always #5 clk = ~clk;

    function automatic in_t mk_in(input logic [4:0] rs, input logic [4:0] rt,
                                  input logic urt, input logic ld, input logic [4:0] rw,
                                  input logic br, input logic mwr, input logic mld,
                                  input logic ack);
        in_t r;
        r.rs = rs; r.rt = rt; r.urt = urt; r.ld = ld; r.rw = rw;
        r.br = br; r.mwr = mwr; r.mld = mld; r.ack = ack;
        return r;
    endfunction

    function automatic step_t mk(input in_t in, input logic [7:0] c,
                                 input logic [CNT_W-1:0] n, input logic b);
        step_t s;
        s.in     = in;
        s.e.ctl  = c;
        s.e.cnt  = n;
        s.e.berr = b;
        return s;
    endfunction

    task automatic apply(input in_t in);
        id_rs           = in.rs;
        id_rt           = in.rt;
        id_uses_rt      = in.urt;
        ex_MemtoReg     = in.ld;
        ex_rw           = in.rw;
        ex_branch_taken = in.br;
        mem_MemWr       = in.mwr;
        mem_MemtoReg    = in.mld;
        mem_ack         = in.ack;
    endtask

    task automatic do_reset();
        @(posedge clk);
        rst = 1'b0;
        apply('0);
        @(negedge clk);
        @(posedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0;
        // Hazard-provoking inputs must be masked while in reset.
        apply(mk_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0));
        #1;
        tests++;
        if (ctl !== C_OFF) begin
            fails++; $display("FAIL reset_ctl: got %b want %b", ctl, C_OFF);
        end
        @(negedge clk); #1;
        tests++;
        if (stall_cnt !== '0 || bus_err !== 1'b0 || ctl !== C_OFF) begin
            fails++;
            $display("FAIL reset_state: cnt %0d berr %b ctl %b want 0 0 %b",
                     stall_cnt, bus_err, ctl, C_OFF);
        end
        @(posedge clk);
        rst = 1'b1;
        apply('0);
        sb.push_back(mk('0, C_RUN, '0, 1'b0).e);
        #1;
        e = sb.pop_front();
        tests++;
        if (ctl !== e.ctl) begin
            fails++; $display("FAIL reset_release_ctl: got %b want %b", ctl, e.ctl);
        end
    endtask

    task automatic test_lduse();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(mk(mk_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0), C_LDU, 4'd1, 1'b0));
        s.push_back(mk(mk_in(5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), C_RUN, 4'd1, 1'b0));
        s.push_back(mk(mk_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), C_RUN, 4'd1, 1'b0));
        s.push_back(mk(mk_in(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0), C_LDU, 4'd2, 1'b0));
        s.push_back(mk(mk_in(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0), C_RUN, 4'd2, 1'b0));
        s.push_back(mk(mk_in(5'd9, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0), C_RUN, 4'd2, 1'b0));
        foreach (s[i]) begin
            @(posedge clk); apply(s[i].in); sb.push_back(s[i].e); #1;
            e = sb.pop_front();
            tests++;
            if (ctl !== e.ctl) begin
                fails++; $display("FAIL lduse_ctl[%0d]: got %b want %b", i, ctl, e.ctl);
            end
            @(negedge clk); #1;
            tests++;
            if (stall_cnt !== e.cnt || bus_err !== e.berr) begin
                fails++;
                $display("FAIL lduse_cnt[%0d]: got %0d/%b want %0d/%b",
                         i, stall_cnt, bus_err, e.cnt, e.berr);
            end
        end
    endtask

    task automatic test_branch_lduse();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(mk(mk_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0), C_BR, 4'd0, 1'b0));
        s.push_back(mk(mk_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0), C_BR, 4'd0, 1'b0));
        s.push_back(mk('0, C_RUN, 4'd0, 1'b0));
        foreach (s[i]) begin
            @(posedge clk); apply(s[i].in); sb.push_back(s[i].e); #1;
            e = sb.pop_front();
            tests++;
            if (ctl !== e.ctl) begin
                fails++; $display("FAIL br_lduse_ctl[%0d]: got %b want %b", i, ctl, e.ctl);
            end
            @(negedge clk); #1;
            tests++;
            if (stall_cnt !== e.cnt || bus_err !== e.berr) begin
                fails++;
                $display("FAIL br_lduse_cnt[%0d]: got %0d/%b want %0d/%b",
                         i, stall_cnt, bus_err, e.cnt, e.berr);
            end
        end
    endtask

    task automatic test_mem_wait();
        step_t s[$];
        exp_t  e;
        in_t   ld_wait;
        in_t   ld_done;
        do_reset();
        ld_wait = mk_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        ld_done = mk_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        s.push_back(mk(ld_wait, C_FRZ, 4'd1, 1'b0));
        s.push_back(mk(ld_wait, C_FRZ, 4'd2, 1'b0));
        s.push_back(mk(ld_wait, C_FRZ, 4'd3, 1'b0));
        s.push_back(mk(ld_done, C_RUNR, 4'd3, 1'b0));
        s.push_back(mk('0, C_RUN, 4'd3, 1'b0));
        // Zero-stall access, stray ack, and store acked immediately.
        s.push_back(mk(ld_done, C_RUNR, 4'd3, 1'b0));
        s.push_back(mk(mk_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1), C_RUN, 4'd3, 1'b0));
        s.push_back(mk(mk_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1), C_RUNR, 4'd3, 1'b0));
        // Load-use hidden by a freeze re-presents on the release cycle.
        s.push_back(mk(mk_in(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0), C_FRZ, 4'd4, 1'b0));
        s.push_back(mk(mk_in(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1), C_LDUR, 4'd5, 1'b0));
        s.push_back(mk('0, C_RUN, 4'd5, 1'b0));
        foreach (s[i]) begin
            @(posedge clk); apply(s[i].in); sb.push_back(s[i].e); #1;
            e = sb.pop_front();
            tests++;
            if (ctl !== e.ctl) begin
                fails++; $display("FAIL memwait_ctl[%0d]: got %b want %b", i, ctl, e.ctl);
            end
            @(negedge clk); #1;
            tests++;
            if (stall_cnt !== e.cnt || bus_err !== e.berr) begin
                fails++;
                $display("FAIL memwait_cnt[%0d]: got %0d/%b want %0d/%b",
                         i, stall_cnt, bus_err, e.cnt, e.berr);
            end
        end
    endtask

    task automatic test_branch_freeze();
        step_t s[$];
        exp_t  e;
        in_t   bw;
        do_reset();
        bw = mk_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        s.push_back(mk(bw, C_FRZ, 4'd1, 1'b0));
        s.push_back(mk(bw, C_FRZ, 4'd2, 1'b0));
        s.push_back(mk(mk_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1), C_BRR, 4'd2, 1'b0));
        s.push_back(mk('0, C_RUN, 4'd2, 1'b0));
        foreach (s[i]) begin
            @(posedge clk); apply(s[i].in); sb.push_back(s[i].e); #1;
            e = sb.pop_front();
            tests++;
            if (ctl !== e.ctl) begin
                fails++; $display("FAIL br_freeze_ctl[%0d]: got %b want %b", i, ctl, e.ctl);
            end
            @(negedge clk); #1;
            tests++;
            if (stall_cnt !== e.cnt || bus_err !== e.berr) begin
                fails++;
                $display("FAIL br_freeze_cnt[%0d]: got %0d/%b want %0d/%b",
                         i, stall_cnt, bus_err, e.cnt, e.berr);
            end
        end
    endtask

    task automatic test_timeout();
        step_t s[$];
        exp_t  e;
        in_t   st;
        do_reset();
        st = mk_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        // Five frozen edges: RUN->WAIT, then tcnt 1..4, the last one entering ERR.
        for (int k = 1; k <= 5; k++) s.push_back(mk(st, C_FRZ, CNT_W'(k), k == 5));
        s.push_back(mk(st, C_ERR, 4'd6, 1'b1));
        s.push_back(mk(mk_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1), C_ERR, 4'd7, 1'b1));
        s.push_back(mk('0, C_ERR, 4'd8, 1'b1));
        s.push_back(mk(st, C_ERR, 4'd9, 1'b1));
        foreach (s[i]) begin
            @(posedge clk); apply(s[i].in); sb.push_back(s[i].e); #1;
            e = sb.pop_front();
            tests++;
            if (ctl !== e.ctl) begin
                fails++; $display("FAIL timeout_ctl[%0d]: got %b want %b", i, ctl, e.ctl);
            end
            @(negedge clk); #1;
            tests++;
            if (stall_cnt !== e.cnt || bus_err !== e.berr) begin
                fails++;
                $display("FAIL timeout_cnt[%0d]: got %0d/%b want %0d/%b",
                         i, stall_cnt, bus_err, e.cnt, e.berr);
            end
        end
        // Asynchronous reset in the middle of a cycle, away from any clock edge.
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (bus_err !== 1'b0 || stall_cnt !== '0 || ctl !== C_OFF) begin
            fails++;
            $display("FAIL timeout_async_rst: berr %b cnt %0d ctl %b want 0 0 %b",
                     bus_err, stall_cnt, ctl, C_OFF);
        end
        @(posedge clk);
        rst = 1'b1;
        apply('0);
        #1;
        tests++;
        if (ctl !== C_RUN) begin
            fails++; $display("FAIL timeout_after_rst_ctl: got %b want %b", ctl, C_RUN);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        in_t  st;
        do_reset();
        st = mk_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            apply(st);
            sb.push_back(mk(st, (k <= 5) ? C_FRZ : C_ERR,
                            (k >= 15) ? 4'd15 : CNT_W'(k), k >= 5).e);
            #1;
            e = sb.pop_front();
            tests++;
            if (ctl !== e.ctl) begin
                fails++; $display("FAIL sat_ctl[%0d]: got %b want %b", k, ctl, e.ctl);
            end
            @(negedge clk); #1;
            tests++;
            if (stall_cnt !== e.cnt || bus_err !== e.berr) begin
                fails++;
                $display("FAIL sat_cnt[%0d]: got %0d/%b want %0d/%b",
                         k, stall_cnt, bus_err, e.cnt, e.berr);
            end
        end
        do_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        apply('0);
        test_reset();
        test_lduse();
        test_branch_lduse();
        test_mem_wait();
        test_branch_freeze();
        test_timeout();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
